// File: rtl/seg_pkg.sv
// Shared types, segment patterns and decode helper for the decimal display stage.
package seg_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CONVERT = 2'd1,
    COMMIT  = 2'd2
  } seg_state_t;

  localparam int unsigned BIN_W      = 16;
  localparam int unsigned BCD_DIGITS = 5;
  localparam int unsigned BCD_W      = 4 * BCD_DIGITS;

  localparam logic [7:0] SEG_BLANK = 8'hFF;

  // Active-low {dp, g..a}; index 0 is the rightmost entry.
  localparam logic [15:0][7:0] SEG_DIGIT = {
    8'h8E, 8'h86, 8'hA1, 8'hC6, 8'h83, 8'h88, 8'h90, 8'h80,
    8'hF8, 8'h82, 8'h92, 8'h99, 8'hB0, 8'hA4, 8'hF9, 8'hC0
  };

  function automatic logic [7:0] seg_decode(input logic [3:0] v);
    return SEG_DIGIT[v];
  endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Sequential 16-bit double-dabble engine: one add-3/shift iteration per cycle, 16 iterations.
module bin2bcd_seq
  import seg_pkg::*;
(
  input  logic               clock,
  input  logic               reset,
  input  logic               start,
  input  logic [BIN_W-1:0]   bin,
  output logic               busy,
  output logic               done,
  output logic [BCD_W-1:0]   bcd
);

  logic [BIN_W-1:0] bin_q, bin_d;
  logic [BCD_W-1:0] bcd_q, bcd_d, adj;
  logic [3:0]       cnt_q, cnt_d;
  logic             busy_q, busy_d;

  always_comb begin
    adj = bcd_q;
    for (int i = 0; i < BCD_DIGITS; i++) begin
      if (bcd_q[4*i +: 4] >= 4'd5) adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
    end

    bin_d  = bin_q;
    bcd_d  = bcd_q;
    cnt_d  = cnt_q;
    busy_d = busy_q;
    if (start) begin
      bin_d  = bin;
      bcd_d  = '0;
      cnt_d  = '0;
      busy_d = 1'b1;
    end else if (busy_q) begin
      {bcd_d, bin_d} = {adj[BCD_W-2:0], bin_q, 1'b0};
      cnt_d          = cnt_q + 4'd1;
      if (cnt_q == 4'd15) busy_d = 1'b0;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      bin_q  <= '0;
      bcd_q  <= '0;
      cnt_q  <= '0;
      busy_q <= 1'b0;
    end else begin
      bin_q  <= bin_d;
      bcd_q  <= bcd_d;
      cnt_q  <= cnt_d;
      busy_q <= busy_d;
    end
  end

  // done flags the final iteration: bcd is complete right after this edge.
  assign done = busy_q && (cnt_q == 4'd15);
  assign busy = busy_q;
  assign bcd  = bcd_q;

endmodule

// File: rtl/seg_decimal_display.sv
// Six-digit seven-segment display: seg1 in decimal on hex4..hex0, one seg2 nibble in hex on hex5.
// Optional leading-zero blanking when SEG_ZERO_BLANK_EN is defined.
module seg_decimal_display
  import seg_pkg::*;
#(
  parameter int unsigned NIBBLE_SEL = 0
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [15:0] seg1,
  input  logic [15:0] seg2,
  output logic [7:0]  hex0,
  output logic [7:0]  hex1,
  output logic [7:0]  hex2,
  output logic [7:0]  hex3,
  output logic [7:0]  hex4,
  output logic [7:0]  hex5,
  output logic        busy
);

  // Input capture is a plain pipeline stage; it keeps sampling during reset so the
  // forced post-reset conversion picks up the live seg1 value.
  logic [15:0] in_q, diag_q;

  always_ff @(posedge clock) begin
    in_q   <= seg1;
    diag_q <= seg2;
  end

  seg_state_t                       state_q, state_d;
  logic [15:0]                      shown_q, shown_d;
  logic                             pending_q, pending_d;
  logic                             busy_q, busy_d;
  logic [BCD_DIGITS-1:0][7:0]       hex_q, hex_d;
  logic [7:0]                       hex5_q, hex5_d;
  logic [BCD_DIGITS-1:0][7:0]       commit_seg;
  logic                             start;
  logic                             eng_busy, eng_done;
  logic [BCD_W-1:0]                 eng_bcd;
  logic                             lead;

  assign start = (state_q == IDLE) && (pending_q || (in_q != shown_q));

  bin2bcd_seq u_bcd (
    .clock (clock),
    .reset (reset),
    .start (start),
    .bin   (in_q),
    .busy  (eng_busy),
    .done  (eng_done),
    .bcd   (eng_bcd)
  );

  always_comb begin
    lead = 1'b1;
    for (int i = 0; i < BCD_DIGITS; i++) commit_seg[i] = seg_decode(eng_bcd[4*i +: 4]);
`ifdef SEG_ZERO_BLANK_EN
    // Blank from the top down until the first non-zero digit; hex0 always shows.
    for (int i = BCD_DIGITS - 1; i >= 1; i--) begin
      if (lead && (eng_bcd[4*i +: 4] == 4'd0)) commit_seg[i] = SEG_BLANK;
      else                                     lead = 1'b0;
    end
`endif
  end

  always_comb begin
    state_d   = state_q;
    shown_d   = shown_q;
    pending_d = pending_q;
    hex_d     = hex_q;
    hex5_d    = seg_decode(diag_q[4*NIBBLE_SEL +: 4]);
    case (state_q)
      IDLE: begin
        if (start) begin
          shown_d   = in_q;
          pending_d = 1'b0;
          state_d   = CONVERT;
        end
      end
      CONVERT: if (eng_done) state_d = COMMIT;
      COMMIT: begin
        hex_d   = commit_seg;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      shown_q   <= '0;
      pending_q <= 1'b1;
      busy_q    <= 1'b0;
      hex_q     <= {BCD_DIGITS{SEG_BLANK}};
      hex5_q    <= SEG_BLANK;
    end else begin
      state_q   <= state_d;
      shown_q   <= shown_d;
      pending_q <= pending_d;
      busy_q    <= busy_d;
      hex_q     <= hex_d;
      hex5_q    <= hex5_d;
    end
  end

  assign hex0 = hex_q[0];
  assign hex1 = hex_q[1];
  assign hex2 = hex_q[2];
  assign hex3 = hex_q[3];
  assign hex4 = hex_q[4];
  assign hex5 = hex5_q;
  assign busy = busy_q;

endmodule

// File: tb/tb_seg_decimal_display.sv
// Bench for seg_decimal_display: cycle model (countdown + decimal arithmetic) compared every cycle,
// directed scenarios with literal expectations, then randomized seg1/seg2 traffic.
module tb_seg_decimal_display;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [15:0] seg1  = 16'd0;
  logic [15:0] seg2  = 16'd0;

  logic [7:0] a_hex0, a_hex1, a_hex2, a_hex3, a_hex4, a_hex5;
  logic [7:0] b_hex0, b_hex1, b_hex2, b_hex3, b_hex4, b_hex5;
  logic       a_busy, b_busy;

  int total = 0;
  int bad   = 0;

  always #5 clock = ~clock;

  seg_decimal_display #(.NIBBLE_SEL(0)) dut_a (
    .clock(clock), .reset(reset), .seg1(seg1), .seg2(seg2),
    .hex0(a_hex0), .hex1(a_hex1), .hex2(a_hex2), .hex3(a_hex3), .hex4(a_hex4),
    .hex5(a_hex5), .busy(a_busy)
  );

  seg_decimal_display #(.NIBBLE_SEL(1)) dut_b (
    .clock(clock), .reset(reset), .seg1(seg1), .seg2(seg2),
    .hex0(b_hex0), .hex1(b_hex1), .hex2(b_hex2), .hex3(b_hex3), .hex4(b_hex4),
    .hex5(b_hex5), .busy(b_busy)
  );

  // Active-low {dp,g..a} patterns for 0..F.
  logic [7:0] tab [16] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                           8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};

  function automatic logic [39:0] digits_of(input int v);
    logic [39:0] r;
    int p;
    p = 1;
    for (int i = 0; i < 5; i++) begin
      r[8*i +: 8] = tab[(v / p) % 10];
`ifdef SEG_ZERO_BLANK_EN
      if (i > 0 && v < p) r[8*i +: 8] = 8'hFF;
`endif
      p = p * 10;
    end
    return r;
  endfunction

  // Model: a conversion is just "value v, committed 17 edges after it was taken".
  logic [15:0] m_in = 16'd0, m_diag = 16'd0;
  logic [15:0] m_shown, m_val;
  logic        m_busy, m_pend;
  int          m_cnt;
  logic [39:0] m_hex;
  logic [7:0]  m_hex5a, m_hex5b;

  always @(posedge clock) begin
    m_in   <= seg1;
    m_diag <= seg2;
  end

  always @(posedge clock or posedge reset) begin
    if (reset) begin
      m_busy <= 1'b0; m_pend <= 1'b1; m_shown <= 16'd0; m_val <= 16'd0; m_cnt <= 0;
      m_hex <= {5{8'hFF}}; m_hex5a <= 8'hFF; m_hex5b <= 8'hFF;
    end else begin
      m_hex5a <= tab[m_diag[3:0]];
      m_hex5b <= tab[m_diag[7:4]];
      if (!m_busy) begin
        if (m_pend || m_in != m_shown) begin
          m_busy <= 1'b1; m_val <= m_in; m_shown <= m_in; m_pend <= 1'b0; m_cnt <= 0;
        end
      end else if (m_cnt == 16) begin
        m_busy <= 1'b0;
        m_hex  <= digits_of(int'(m_val));
      end else begin
        m_cnt <= m_cnt + 1;
      end
    end
  end

  task automatic chk(input string name, input logic [39:0] act, input logic [39:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  logic started = 1'b0;
  always @(posedge clock) started <= 1'b1;

  always @(negedge clock) begin
    if (started) begin
      chk("digits_a", {a_hex4, a_hex3, a_hex2, a_hex1, a_hex0}, m_hex);
      chk("digits_b", {b_hex4, b_hex3, b_hex2, b_hex1, b_hex0}, m_hex);
      chk("hex5_a", {32'd0, a_hex5}, {32'd0, m_hex5a});
      chk("hex5_b", {32'd0, b_hex5}, {32'd0, m_hex5b});
      chk("busy_a", {39'd0, a_busy}, {39'd0, m_busy});
      chk("busy_b", {39'd0, b_busy}, {39'd0, m_busy});
    end
  end

  task automatic edges(input int n);
    repeat (n) @(posedge clock);
    #2;
  endtask

  localparam logic [7:0] ZB = 8'hC0;
`ifdef SEG_ZERO_BLANK_EN
  localparam logic [7:0] LZ = 8'hFF;
`else
  localparam logic [7:0] LZ = 8'hC0;
`endif

  int busy_cycles;

  initial begin
    // Reset with zeros: blank during reset, "0" (or "00000") 18 edges after release.
    edges(3);
    chk("rst_hex0", {32'd0, a_hex0}, {32'd0, 8'hFF});
    chk("rst_hex5", {32'd0, a_hex5}, {32'd0, 8'hFF});
    chk("rst_busy", {39'd0, a_busy}, 40'd0);
    reset = 1'b0;
    edges(18);
    chk("pwr_zero", {a_hex4, a_hex3, a_hex2, a_hex1, a_hex0}, {LZ, LZ, LZ, LZ, ZB});
    edges(5);

    // 0 -> 65535: busy for exactly 17 cycles, digits 6,5,5,3,5.
    seg1 = 16'hFFFF;
    busy_cycles = 0;
    repeat (25) begin
      @(negedge clock);
      if (a_busy) busy_cycles++;
    end
    chk("busy_len", 40'(busy_cycles), 40'd17);
    chk("max_val", {a_hex4, a_hex3, a_hex2, a_hex1, a_hex0}, {8'h82, 8'h92, 8'h92, 8'hB0, 8'h92});
    edges(3);

    // 1234 then 9 three cycles later.
    seg1 = 16'd1234;
    edges(3);
    seg1 = 16'd9;
    edges(45);
    chk("late_nine", {a_hex4, a_hex3, a_hex2, a_hex1, a_hex0}, {LZ, LZ, LZ, LZ, 8'h90});

    // hex5 nibble selection.
    seg2 = 16'h00A5;
    edges(2);
    chk("hex5_sel0", {32'd0, a_hex5}, {32'd0, 8'h92});
    chk("hex5_sel1", {32'd0, b_hex5}, {32'd0, 8'h88});

    // Reset in the middle of converting 500, release with 77.
    seg1 = 16'd500;
    edges(10);
    reset = 1'b1;
    seg1  = 16'd77;
    edges(2);
    chk("mid_rst_blank", {a_hex4, a_hex3, a_hex2, a_hex1, a_hex0}, {5{8'hFF}});
    reset = 1'b0;
    edges(18);
    chk("post_rst_77", {a_hex4, a_hex3, a_hex2, a_hex1, a_hex0}, {LZ, LZ, LZ, 8'hF8, 8'hF8});

    // Hold steady for 100 cycles: per-cycle compare enforces busy=0 and stable digits.
    edges(100);
    chk("steady_busy", {39'd0, a_busy}, 40'd0);

    // Randomized traffic: bursts of changes, holds, extreme values, one stray reset.
    for (int i = 0; i < 600; i++) begin
      case ($urandom_range(0, 9))
        0:       seg1 = 16'hFFFF;
        1:       seg1 = 16'd0;
        2, 3:    seg1 = 16'($urandom_range(0, 99));
        4:       seg1 = 16'($urandom);
        default: ;
      endcase
      if ($urandom_range(0, 3) == 0) seg2 = 16'($urandom);
      if (i == 300) reset = 1'b1;
      if (i == 302) reset = 1'b0;
      edges($urandom_range(1, 12));
    end
    edges(40);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
